// File: rtl/alu_seq_addsub.sv
// Multi-cycle ADD/SUB/AND/XOR ALU: CHUNK bits per cycle with a registered ripple carry,
// valid/ready on both sides, ZF/SF/OF computed once the full result is assembled.
module alu_seq_addsub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_XOR = 2'b11} op_t;

  state_t           r_state, w_next_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_zf, r_sf, r_of;

  logic             w_accept, w_last, w_cin, w_of;
  logic [IW-1:0]    w_base;
  logic [CHUNK-1:0] w_a_chunk, w_b_chunk, w_b_eff, w_chunk_res;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_full;

  assign w_last = (r_cnt == CW'(N - 1));

  // NOTE: every signal driven from always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          w_accept     = in_valid;
          w_next_state = in_valid ? S_BUSY : S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // One chunk slice of the latched operands; SUB is A + ~B + 1 with the +1 injected at chunk 0.
  always_comb begin
    w_base      = IW'(r_cnt) * IW'(CHUNK);
    w_a_chunk   = r_a[w_base +: CHUNK];
    w_b_chunk   = r_b[w_base +: CHUNK];
    w_b_eff     = (r_op == OP_SUB) ? ~w_b_chunk : w_b_chunk;
    w_cin       = (r_cnt == '0) ? (r_op == OP_SUB) : r_carry;
    w_sum       = {1'b0, w_a_chunk} + {1'b0, w_b_eff} + {{CHUNK{1'b0}}, w_cin};
    w_chunk_res = w_sum[CHUNK-1:0];
    case (r_op)
      OP_AND:  w_chunk_res = w_a_chunk & w_b_chunk;
      OP_XOR:  w_chunk_res = w_a_chunk ^ w_b_chunk;
      default: w_chunk_res = w_sum[CHUNK-1:0];
    endcase
    w_full = r_acc;
    w_full[w_base +: CHUNK] = w_chunk_res;
    w_of = 1'b0;
    if (r_op == OP_ADD) w_of = (r_a[M] == r_b[M]) && (w_full[M] != r_a[M]);
    if (r_op == OP_SUB) w_of = (r_a[M] != r_b[M]) && (w_full[M] != r_a[M]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
      r_of     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_op    <= op_t'(op);
        r_cnt   <= '0;
        r_carry <= 1'b0;
      end else if (r_state == S_BUSY) begin
        r_acc   <= w_full;
        r_carry <= w_sum[CHUNK];
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        // Outputs update only once the whole word exists; partial sums never reach the port.
        if (w_last) begin
          r_result <= w_full;
          r_zf     <= (w_full == '0);
          r_sf     <= w_full[M];
          r_of     <= w_of;
        end
      end
    end
  end

  assign result = r_result;
  assign zf     = r_zf;
  assign sf     = r_sf;
  assign of     = r_of;

endmodule

// File: tb/tb_alu_seq_addsub.sv
// Self-checking bench for alu_seq_addsub: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model and a timing model.
module tb_alu_seq_addsub;
  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int N     = WIDTH / CHUNK;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, XOR_ = 2'b11;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zf, sf, of;
  logic [1:0]  op;
  logic [63:0] a, b, result;

  always #5 clk = ~clk;

  alu_seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zf(zf), .sf(sf), .of(of)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] res;
    logic        z, s, o;
    longint      due;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;

  // Reference: exact signed arithmetic on 65 bits; overflow means the true sum left the 64-bit range.
  function automatic exp_t model(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    logic signed [64:0] w;
    e = '{default: 0};
    w = '0;
    case (f)
      ADD:  w = $signed({x[63], x}) + $signed({y[63], y});
      SUB:  w = $signed({x[63], x}) - $signed({y[63], y});
      AND_: e.res = x & y;
      default: e.res = x ^ y;
    endcase
    if (f == ADD || f == SUB) begin
      e.res = w[63:0];
      e.o   = (w[64] != w[63]);
    end
    e.z = (e.res == 64'd0);
    e.s = e.res[63];
    return e;
  endfunction

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin : monitor
    exp_t e;
    logic exp_v;
    if (rst_n) begin
      cyc++;
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(op, a, b);
        e.due = cyc + N;
        q.push_back(e);
      end
      #1;
      if (rst_n) begin
        exp_v = (q.size() > 0) && (cyc >= q[0].due);
        check("cyc.out_valid", out_valid, exp_v);
        check("cyc.in_ready", in_ready, (q.size() == 0) || (exp_v && out_ready));
        if (exp_v) begin
          check("cyc.result", result, q[0].res);
          check("cyc.zf", zf, q[0].z);
          check("cyc.sf", sf, q[0].s);
          check("cyc.of", of, q[0].o);
        end
      end
    end
  end

  task automatic start_op(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    in_valid = 1'b1; op = f; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; a = ONES; b = ONES;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("timeout.out_valid", 64'd0, 64'd1);
  endtask

  task automatic run(input string nm, input logic [1:0] f, input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] er, input logic ez, input logic es, input logic eo);
    int lat;
    start_op(f, x, y);
    wait_valid(lat);
    check({nm, ".latency"}, 64'(lat), 64'(N));
    check({nm, ".result"}, result, er);
    check({nm, ".zf"}, zf, ez);
    check({nm, ".sf"}, sf, es);
    check({nm, ".of"}, of, eo);
  endtask

  initial begin
    int lat;
    logic [63:0] held;
    rst_n = 1'b0; in_valid = 1'b0; op = ADD; a = '0; b = '0; out_ready = 1'b1;
    #1;
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.result", result, 64'd0);
    check("reset.flags", {zf, sf, of}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("add_basic", ADD, 64'd620, -64'sd34, 64'd586, 1'b0, 1'b0, 1'b0);
    run("add_ovf_pos", ADD, MAXP, 64'd1, MINN, 1'b0, 1'b1, 1'b1);
    run("add_ovf_neg", ADD, MINN, ONES, MAXP, 1'b0, 1'b0, 1'b1);
    run("sub_neg1", SUB, 64'd0, 64'd1, ONES, 1'b0, 1'b1, 1'b0);
    run("sub_zero", SUB, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0);
    run("sub_ovf", SUB, MINN, 64'd1, MAXP, 1'b0, 1'b0, 1'b1);
    run("and_basic", AND_, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, 1'b0);
    run("and_msb", AND_, MINN, MINN, MINN, 1'b0, 1'b1, 1'b0);
    run("xor_self", XOR_, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 1'b0, 1'b0);

    // Stall in DONE with in_valid asserted (junk must be ignored), then back-to-back accept.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = ADD; a = 64'd100; b = ONES;
    @(negedge clk);
    op = XOR_; a = 64'hDEAD; b = 64'hBEEF;
    wait_valid(lat);
    check("stall.latency", 64'(lat), 64'(N));
    check("stall.result", result, 64'd99);
    held = result;
    repeat (10) begin
      @(negedge clk);
      check("stall.hold_result", result, held);
      check("stall.in_ready", in_ready, 1'b0);
      check("stall.out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1; op = ADD; a = 64'd3; b = 64'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b.out_valid_fell", out_valid, 1'b0);
    wait_valid(lat);
    check("b2b.latency", 64'(lat), 64'(N));
    check("b2b.result", result, 64'd7);

    // Abort with reset during chunk 2 of a carry-propagating add.
    start_op(ADD, ONES, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.in_ready", in_ready, 1'b1);
    check("abort.result", result, 64'd0);
    check("abort.flags", {zf, sf, of}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", ADD, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
